// File: rtl/adma_data_fifo.sv
// Synchronous first-word fall-through data FIFO between the ADMA engine and the SD data path.
// Optional almost_full/almost_empty watermarks are built when ADMA_FIFO_WATERMARK_EN is defined.
module adma_data_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic                  err_clear,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
`ifdef ADMA_FIFO_WATERMARK_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LVL_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push_acc, pop_acc;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];

   // Handshake: a pop is taken when rd_en is high and the FIFO holds a word; a push
   // is taken when wr_en is high and there is room, where a same-cycle pop frees room.
   // Refused requests are not retried; they only raise the sticky error flags.
   always_comb begin
      pop_acc     = rd_en & ~empty & ~flush;
      push_acc    = wr_en & (~full | pop_acc) & ~flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         level_d = level_q + LVL_W'(push_acc) - LVL_W'(pop_acc);
         // A new error event in the same cycle as err_clear keeps the flag set.
         overflow_d  = (overflow_q  & ~err_clear) | (wr_en & ~push_acc);
         underflow_d = (underflow_q & ~err_clear) | (rd_en & empty);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_acc & ~RESET) mem_q[wr_ptr_q] <= wr_data;
   end

`ifdef ADMA_FIFO_WATERMARK_EN
   assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));
   assign almost_empty = (level_q <= LVL_W'(AE_LEVEL));
`else
   logic wm_unused;
   assign wm_unused = (level_q >= LVL_W'(AF_LEVEL)) ^ (level_q <= LVL_W'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_adma_data_fifo.sv
// Directed and randomized bench for adma_data_fifo against a queue-based reference model.
// Watermark outputs are checked only when ADMA_FIFO_WATERMARK_EN is defined.
module tb_adma_data_fifo;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        flush = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        rd_en = 1'b0;
   logic        err_clear = 1'b0;
   logic [31:0] rd_data;
   logic        full, empty, overflow, underflow;
   logic [4:0]  level;
`ifdef ADMA_FIFO_WATERMARK_EN
   logic        almost_full, almost_empty;
`endif

   adma_data_fifo dut (
      .CLK(CLK), .RESET(RESET), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .err_clear(err_clear), .rd_data(rd_data), .full(full),
      .empty(empty), .level(level), .overflow(overflow), .underflow(underflow)
`ifdef ADMA_FIFO_WATERMARK_EN
      , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: contents as a queue plus the two sticky flags.
   logic [31:0] exp_q[$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int n;
      n = exp_q.size();
      chk({tag, ".rd_data"},   rd_data,   (n > 0) ? exp_q[0] : 32'h0);
      chk({tag, ".level"},     {27'h0, level}, 32'(n));
      chk({tag, ".empty"},     {31'h0, empty}, 32'(n == 0));
      chk({tag, ".full"},      {31'h0, full},  32'(n == 16));
      chk({tag, ".overflow"},  {31'h0, overflow},  {31'h0, m_ovf});
      chk({tag, ".underflow"}, {31'h0, underflow}, {31'h0, m_unf});
`ifdef ADMA_FIFO_WATERMARK_EN
      chk({tag, ".almost_full"},  {31'h0, almost_full},  32'(n >= 12));
      chk({tag, ".almost_empty"}, {31'h0, almost_empty}, 32'(n <= 4));
`endif
   endtask

   task automatic model_step(input logic r, input logic w, input logic [31:0] d,
                             input logic p, input logic f, input logic c);
      int  n;
      logic pop_ok, push_ok;
      n = exp_q.size();
      if (r || f) begin
         exp_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         pop_ok  = p && (n > 0);
         push_ok = w && ((n < 16) || pop_ok);
         if (pop_ok)  void'(exp_q.pop_front());
         if (push_ok) exp_q.push_back(d);
         m_ovf = (m_ovf && !c) || (w && !push_ok);
         m_unf = (m_unf && !c) || (p && (n == 0));
      end
   endtask

   // Drive one cycle's inputs, clock it, update the model, then check at the falling edge.
   task automatic cyc(input string tag, input logic r, input logic w, input logic [31:0] d,
                      input logic p, input logic f, input logic c);
      RESET = r; wr_en = w; wr_data = d; rd_en = p; flush = f; err_clear = c;
      @(posedge CLK);
      model_step(r, w, d, p, f, c);
      @(negedge CLK);
      RESET = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clear = 1'b0;
      check_all(tag);
   endtask

   initial begin
      int pmode;
      @(negedge CLK);
      // Reset and single-word round trip
      cyc("rst0", 1, 0, 0, 0, 0, 0);
      cyc("rst1", 1, 0, 0, 0, 0, 0);
      cyc("push1", 0, 1, 32'hA5A5_0001, 0, 0, 0);
      cyc("pop1", 0, 0, 0, 1, 0, 0);
      // Fill, overflow, drain in order
      for (int i = 0; i < 16; i++) cyc("fill", 0, 1, 32'(i), 0, 0, 0);
      cyc("ovf", 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc("drain", 0, 0, 0, 1, 0, 0);
      cyc("eclr_ovf", 0, 0, 0, 0, 0, 1);
      // Pointer wraparound
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) cyc("wrap_push", 0, 1, 32'h100 + 32'(k * 10 + i), 0, 0, 0);
         for (int i = 0; i < 10; i++) cyc("wrap_pop", 0, 0, 0, 1, 0, 0);
      end
      // Simultaneous push/pop at full, then at empty
      for (int i = 0; i < 16; i++) cyc("fill2", 0, 1, 32'h200 + 32'(i), 0, 0, 0);
      cyc("full_rw", 0, 1, 32'h1234_5678, 1, 0, 0);
      for (int i = 0; i < 16; i++) cyc("drain2", 0, 0, 0, 1, 0, 0);
      cyc("empty_rw", 0, 1, 32'h0BAD_F00D, 1, 0, 0);
      cyc("pop_one", 0, 0, 0, 1, 0, 0);
      cyc("eclr_unf", 0, 0, 0, 0, 0, 1);
      // Flush with pending push clears overflow at level 7
      for (int i = 0; i < 16; i++) cyc("fill3", 0, 1, 32'h300 + 32'(i), 0, 0, 0);
      cyc("ovf3", 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc("to7", 0, 0, 0, 1, 0, 0);
      cyc("flush_wr", 0, 1, 32'h5555_AAAA, 0, 1, 0);
      cyc("after_flush", 0, 0, 0, 0, 0, 0);
      // Underflow, clear, and clear colliding with a new event
      cyc("unf", 0, 0, 0, 1, 0, 0);
      cyc("eclr", 0, 0, 0, 0, 0, 1);
      cyc("unf_vs_clr", 0, 0, 0, 1, 0, 1);
      cyc("eclr2", 0, 0, 0, 0, 0, 1);
      // Reset mid-burst
      for (int i = 0; i < 5; i++) cyc("burst", 0, 1, $urandom, 0, 0, 0);
      cyc("rst_mid", 1, 1, 32'h7777_7777, 1, 0, 0);
      // Randomized traffic with a drifting push bias so both full and empty are reached
      pmode = 50;
      for (int i = 0; i < 600; i++) begin
         if ((i % 60) == 0) pmode = $urandom_range(15, 85);
         cyc("rand",
             ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < pmode),
             $urandom,
             ($urandom_range(0, 99) >= pmode),
             ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 9) == 0));
      end
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
